demleyici: RTL and testbench
============================

// Module: demleyici
// PURPOSE
//   Brew stage directly downstream of the grinder. Collects grounds from each grinder
//   done pulse in a saturating hopper. On a brew request it snapshots the hopper and
//   runs a heat/brew/dispense FSM. It then reports the cup count for that batch.
//   Grounds that arrive while brewing are kept for the next batch.
// PARAMETERS
//   KAPASITE       100  hopper capacity in grounds (max 127)
//   MIN_TANECIK    8    minimum grounds for a brew to be accepted (>=1)
//   ISITMA_SURESI  4    heat phase length in cycles (>=1)
//   FINCAN_LOG2    3    grounds per cup = 2**FINCAN_LOG2
// PORTS
//   saat             in   1  clock, rising edge
//   reset            in   1  synchronous, active-high
//   tanecik_gecerli  in   1  grinder done pulse; tanecikler valid this cycle
//   tanecikler       in   5  ground count from grinder (0..31)
//   demle            in   1  brew request, level sampled every cycle
//   mesgul           out  1  FSM not in BOSTA
//   hazir            out  1  one-cycle pulse during BOSALT
//   fincan           out  4  cups of last completed batch, held until next BOSALT
//   hata             out  1  one-cycle pulse: request rejected for too few grounds
//   birikmis         out  7  current hopper content
//   dolu             out  1  birikmis == KAPASITE
// BEHAVIOUR
//   - Reset: all outputs 0, hopper 0, state BOSTA. Reset mid-brew aborts the batch
//     and clears the hopper. No hazir is produced.
//   - Hopper: when tanecik_gecerli=1, birikmis <= min(birikmis+tanecikler, KAPASITE).
//     Use an 8-bit intermediate sum. tanecikler=0 leaves the hopper unchanged. The
//     hopper accepts in every state.
//   - FSM states: BOSTA -> ISIT -> DEMLE -> BOSALT -> BOSTA.
//   - BOSTA, demle=1, birikmis>=MIN_TANECIK (accepting edge):
//     snapshot S <= birikmis, hopper cleared, state goes to ISIT.
//     Grounds arriving in the same cycle land in the cleared hopper, not in S.
//   - BOSTA, demle=1, birikmis<MIN_TANECIK: hata=1 for one cycle, stay in BOSTA,
//     hopper untouched. Holding demle repeats hata each cycle.
//   - demle outside BOSTA: ignored, no hata.
//   - ISIT: lasts ISITMA_SURESI cycles. DEMLE: lasts S cycles (one 7-bit down-counter
//     is reused for both phases). BOSALT: 1 cycle with hazir=1 and fincan=S>>FINCAN_LOG2.
//   - Timing: mesgul=1 from the accepting edge. hazir is high after edge
//     ISITMA_SURESI+S counted from the accepting edge. mesgul falls one edge later.
//   - In BOSALT with demle=1: not accepted. The earliest new accept is in the next
//     BOSTA cycle.
//   - All outputs are registered; there are no combinational input->output paths.
// STRUCTURE
//   - Shared package kahve_pkg holds:
//     - state encodings (BOSTA, ISIT, DEMLE, BOSALT, 2 bits);
//     - width constants TANECIK_W=5 and HAZNE_W=7;
//     - FINCAN_W=4.
//     The grinder and this block import it.
//   - One sub-module, tanecik_haznesi: the saturating hopper with ports add_en, add,
//     clr, level, full. clr wins over add_en, but a same-cycle add is applied after
//     clr, i.e. level <= add.
//   - FSM, phase counter and snapshot register live in demleyici.
// TESTING
//   1. Reset, then pulses of 10 and 6, then demle -> hata=0; S=16.
//      hazir after 4+16=20 edges, fincan=2, birikmis=0.
//   2. Hopper at 5, demle -> hata one cycle, state BOSTA, birikmis stays 5.
//   3. Push 31 four times (124) -> birikmis=100, dolu=1; another pulse keeps it at 100.
//   4. Brew in progress, grinder pulses 9 -> birikmis=9 during DEMLE.
//      fincan reflects only the snapshot.
//   5. Accept with birikmis=12 and a same-cycle pulse of 7 -> S=12, fincan=1,
//      birikmis=7. A mid-DEMLE demle is ignored.
//   6. Assert reset during DEMLE -> next cycle all outputs 0, no hazir pulse.
//      A new brew after refill completes normally.

Source files
------------

// File: rtl/kahve_pkg.sv
// kahve_pkg: definitions shared by the grinder and brew stages.
//   durum_t   - brew FSM state encoding (2 bits)
//   TANECIK_W - width of a grinder ground count
//   HAZNE_W   - width of the hopper level
//   FINCAN_W  - width of the cup count
package kahve_pkg;

  localparam int TANECIK_W = 5;
  localparam int HAZNE_W   = 7;
  localparam int FINCAN_W  = 4;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    ISIT   = 2'd1,
    DEMLE  = 2'd2,
    BOSALT = 2'd3
  } durum_t;

endpackage

// File: rtl/tanecik_haznesi.sv
// tanecik_haznesi: saturating grounds hopper.
//   saat    in  clock, rising edge
//   reset   in  synchronous, active-high; empties the hopper
//   add_en  in  add the 'add' amount this cycle
//   add     in  grounds to add (0..31)
//   clr     in  empty the hopper; a same-cycle add lands in the emptied hopper
//   level   out registered hopper content
//   full    out registered, level == KAPASITE
module tanecik_haznesi
  import kahve_pkg::*;
#(
  parameter int KAPASITE = 100
) (
  input  logic                 saat,
  input  logic                 reset,
  input  logic                 add_en,
  input  logic [TANECIK_W-1:0] add,
  input  logic                 clr,
  output logic [HAZNE_W-1:0]   level,
  output logic                 full
);

  localparam logic [7:0]         KAP_8 = 8'(KAPASITE);
  localparam logic [HAZNE_W-1:0] KAP_7 = HAZNE_W'(KAPASITE);

  logic [HAZNE_W-1:0] base;
  logic [7:0]         sum;
  logic [HAZNE_W-1:0] level_next;

  // Clear is applied first, then any same-cycle add on top of the cleared value.
  always_comb begin
    base       = clr ? '0 : level;
    sum        = {1'b0, base} + {3'b000, add};
    level_next = base;
    if (add_en) begin
      level_next = (sum > KAP_8) ? KAP_7 : sum[HAZNE_W-1:0];
    end
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      level <= '0;
      full  <= 1'b0;
    end else begin
      level <= level_next;
      full  <= (level_next == KAP_7);
    end
  end

endmodule

// File: rtl/demleyici.sv
// demleyici: brew stage downstream of the grinder.
//   saat             in  clock, rising edge
//   reset            in  synchronous, active-high
//   tanecik_gecerli  in  grinder done pulse
//   tanecikler       in  ground count from grinder
//   demle            in  brew request, level sampled
//   mesgul           out FSM not idle
//   hazir            out one-cycle pulse while dispensing
//   fincan           out cups of the last completed batch
//   hata             out one-cycle pulse: request rejected, too few grounds
//   birikmis         out current hopper content
//   dolu             out hopper at capacity
module demleyici
  import kahve_pkg::*;
#(
  parameter int KAPASITE      = 100,
  parameter int MIN_TANECIK   = 8,
  parameter int ISITMA_SURESI = 4,
  parameter int FINCAN_LOG2   = 3
) (
  input  logic                 saat,
  input  logic                 reset,
  input  logic                 tanecik_gecerli,
  input  logic [TANECIK_W-1:0] tanecikler,
  input  logic                 demle,
  output logic                 mesgul,
  output logic                 hazir,
  output logic [FINCAN_W-1:0]  fincan,
  output logic                 hata,
  output logic [HAZNE_W-1:0]   birikmis,
  output logic                 dolu
);

  localparam logic [HAZNE_W-1:0] MIN_7     = HAZNE_W'(MIN_TANECIK);
  localparam logic [HAZNE_W-1:0] ISIT_LOAD = HAZNE_W'(ISITMA_SURESI - 1);

  durum_t             state, state_next;
  logic [HAZNE_W-1:0] cnt, cnt_next;
  logic [HAZNE_W-1:0] snap, snap_next;
  logic [FINCAN_W-1:0] fincan_next;
  logic               hata_next;
  logic               accept;

  tanecik_haznesi #(
    .KAPASITE (KAPASITE)
  ) u_hazne (
    .saat   (saat),
    .reset  (reset),
    .add_en (tanecik_gecerli),
    .add    (tanecikler),
    .clr    (accept),
    .level  (birikmis),
    .full   (dolu)
  );

  // One down-counter serves both timed phases: it is loaded with the heat
  // length on accept and reloaded with the snapshot when heating ends.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    snap_next  = snap;
    hata_next  = 1'b0;
    accept     = 1'b0;
    case (state)
      BOSTA: begin
        if (demle) begin
          if (birikmis >= MIN_7) begin
            accept     = 1'b1;
            state_next = ISIT;
            cnt_next   = ISIT_LOAD;
            snap_next  = birikmis;
          end else begin
            hata_next = 1'b1;
          end
        end
      end
      ISIT: begin
        if (cnt == '0) begin
          state_next = DEMLE;
          cnt_next   = snap - 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DEMLE: begin
        if (cnt == '0) begin
          state_next = BOSALT;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      BOSALT: begin
        state_next = BOSTA;
      end
      default: begin
        state_next = BOSTA;
      end
    endcase
  end

  // Cup count is captured as the FSM enters the dispense cycle so it appears
  // together with hazir and is held until the next batch dispenses.
  always_comb begin
    fincan_next = fincan;
    if (state_next == BOSALT && state != BOSALT) begin
      fincan_next = FINCAN_W'(snap >> FINCAN_LOG2);
    end
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      state <= BOSTA;
      cnt   <= '0;
      snap  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      snap  <= snap_next;
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge saat) begin
    if (reset) begin
      mesgul <= 1'b0;
      hazir  <= 1'b0;
      fincan <= '0;
      hata   <= 1'b0;
    end else begin
      mesgul <= (state_next != BOSTA);
      hazir  <= (state_next == BOSALT);
      fincan <= fincan_next;
      hata   <= hata_next;
    end
  end

endmodule

// File: tb/tb_demleyici.sv
// tb_demleyici: directed scenarios followed by randomized traffic, every
// cycle checked against a latency/arithmetic reference model of the brew stage.
module tb_demleyici;

  localparam int KAP  = 100;
  localparam int MINT = 8;
  localparam int ISI  = 4;
  localparam int FLOG = 3;

  logic       saat = 1'b0;
  logic       reset = 1'b1;
  logic       tanecik_gecerli = 1'b0;
  logic [4:0] tanecikler = '0;
  logic       demle = 1'b0;
  logic       mesgul, hazir, hata, dolu;
  logic [3:0] fincan;
  logic [6:0] birikmis;

  always #5 saat = ~saat;

  demleyici #(
    .KAPASITE      (KAP),
    .MIN_TANECIK   (MINT),
    .ISITMA_SURESI (ISI),
    .FINCAN_LOG2   (FLOG)
  ) dut (
    .saat            (saat),
    .reset           (reset),
    .tanecik_gecerli (tanecik_gecerli),
    .tanecikler      (tanecikler),
    .demle           (demle),
    .mesgul          (mesgul),
    .hazir           (hazir),
    .fincan          (fincan),
    .hata            (hata),
    .birikmis        (birikmis),
    .dolu            (dolu)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: batch completion time is computed as an absolute edge
  // number (accept edge + heat length + snapshot), not by stepping phases.
  int edge_n   = 0;
  int m_hop    = 0;
  int m_snap   = 0;
  int m_done   = 0;
  int m_fincan = 0;
  bit m_active = 0;
  bit e_mesgul = 0, e_hazir = 0, e_hata = 0;

  function automatic int sat(input int x);
    return (x > KAP) ? KAP : x;
  endfunction

  task automatic step(input bit r, input bit v, input int t, input bit d);
    bit acc;
    @(negedge saat);
    reset = r; tanecik_gecerli = v; tanecikler = 5'(t); demle = d;
    @(posedge saat);
    #1;
    edge_n++;
    if (r) begin
      m_hop = 0; m_fincan = 0; m_active = 0;
      e_mesgul = 0; e_hazir = 0; e_hata = 0;
    end else begin
      acc    = !e_mesgul && d && (m_hop >= MINT);
      e_hata = !e_mesgul && d && (m_hop < MINT);
      if (acc) begin
        m_snap   = m_hop;
        m_done   = edge_n + ISI + m_snap;
        m_active = 1;
        m_hop    = v ? sat(t) : 0;
      end else if (v) begin
        m_hop = sat(m_hop + t);
      end
      e_hazir = m_active && (edge_n == m_done);
      if (e_hazir) m_fincan = m_snap >> FLOG;
      e_mesgul = m_active && (edge_n <= m_done);
      m_active = e_mesgul;
    end
    $display("edge %0d r=%0d v=%0d t=%0d d=%0d -> mesgul=%0d hazir=%0d fincan=%0d hata=%0d birikmis=%0d dolu=%0d",
             edge_n, r, v, t, d, mesgul, hazir, fincan, hata, birikmis, dolu);
    check("mesgul", int'(mesgul), int'(e_mesgul));
    check("hazir", int'(hazir), int'(e_hazir));
    check("fincan", int'(fincan), m_fincan);
    check("hata", int'(hata), int'(e_hata));
    check("birikmis", int'(birikmis), m_hop);
    check("dolu", int'(dolu), int'(m_hop == KAP));
  endtask

  // Idle until hazir, returning the number of edges taken (-1 on timeout).
  task automatic wait_hazir(output int n, input bit v, input int t, input int at_edge);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      step(0, (i == at_edge) ? v : 1'b0, t, 0);
      if (hazir) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int hz_seen;

  initial begin
    // 1: basic brew of 10+6 grounds
    step(1, 0, 0, 0);
    check("rst_mesgul", int'(mesgul), 0);
    check("rst_birikmis", int'(birikmis), 0);
    step(0, 1, 10, 0);
    step(0, 1, 6, 0);
    step(0, 0, 0, 1);
    check("s1_hata", int'(hata), 0);
    check("s1_mesgul", int'(mesgul), 1);
    wait_hazir(n, 0, 0, 0);
    check("s1_latency", n, 20);
    check("s1_fincan", int'(fincan), 2);
    check("s1_birikmis", int'(birikmis), 0);
    step(0, 0, 0, 0);
    check("s1_mesgul_fall", int'(mesgul), 0);

    // 2: too few grounds
    step(0, 1, 5, 0);
    step(0, 0, 0, 1);
    check("s2_hata", int'(hata), 1);
    check("s2_mesgul", int'(mesgul), 0);
    check("s2_birikmis", int'(birikmis), 5);
    step(0, 0, 0, 1);
    check("s2_hata_repeat", int'(hata), 1);
    step(0, 0, 0, 0);
    check("s2_hata_clear", int'(hata), 0);

    // 3: saturation
    for (int i = 0; i < 4; i++) step(0, 1, 31, 0);
    check("s3_birikmis", int'(birikmis), 100);
    check("s3_dolu", int'(dolu), 1);
    step(0, 1, 31, 0);
    check("s3_sat_hold", int'(birikmis), 100);

    // 4: grounds arriving mid-brew are kept for the next batch
    step(0, 0, 0, 1);
    wait_hazir(n, 1, 9, 6);
    check("s4_latency", n, 104);
    check("s4_fincan", int'(fincan), 12);
    check("s4_birikmis", int'(birikmis), 9);
    step(0, 0, 0, 0);

    // 5: accept with same-cycle pulse; mid-brew demle ignored
    step(0, 1, 3, 0);
    check("s5_pre", int'(birikmis), 12);
    step(0, 1, 7, 1);
    check("s5_birikmis", int'(birikmis), 7);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("s5_ignored_hata", int'(hata), 0);
    wait_hazir(n, 0, 0, 0);
    check("s5_latency", n, 10);
    check("s5_fincan", int'(fincan), 1);
    step(0, 0, 0, 0);

    // 6: reset mid-DEMLE aborts
    step(0, 1, 10, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("s6_mesgul", int'(mesgul), 0);
    check("s6_fincan", int'(fincan), 0);
    check("s6_birikmis", int'(birikmis), 0);
    hz_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 0);
      if (hazir) hz_seen++;
    end
    check("s6_no_hazir", hz_seen, 0);
    step(0, 1, 16, 0);
    step(0, 0, 0, 1);
    wait_hazir(n, 0, 0, 0);
    check("s6_latency", n, 20);
    check("s6_fincan2", int'(fincan), 2);

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 299) == 0), $urandom_range(0, 1),
           int'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
